segment_scan_hex: RTL
=====================

// Module: segment_scan_hex
// PURPOSE
// Multi-digit time-multiplexed 7-segment hex display driver with tear-free value update,
// leading-zero blanking, per-digit decimal points and PWM brightness. Sits between any
// register/counter producing a packed hex word and the board's segment/anode pins.
// Generalises the single-digit hex glyph decode to DIGITS positions and adds scan timing.
// PARAMETERS
// DIGITS      4      number of digit positions (>=1); digit 0 = least significant nibble
// SCAN_DIV    50000  clock cycles per digit slot; must be multiple of 2**BRIGHT_W (elab error else)
// BRIGHT_W    4      brightness control width; slot split into 2**BRIGHT_W sub-slots
// SEG_ACT_LOW 1      1: o_seg/o_dp active-low; 0: active-high
// AN_ACT_LOW  1      1: o_an active-low; 0: active-high
// PORTS
// i_clk      in   1            system clock
// i_rst      in   1            asynchronous reset, active-high
// i_val      in   4*DIGITS     hex value; nibble k -> digit k
// i_dp       in   DIGITS       decimal point enable per digit
// i_load     in   1            strobe: capture i_val/i_dp into pending register
// i_blank_lz in   1            1: blank leading zero digits
// i_bright   in   BRIGHT_W     brightness; 0 = 1/2**BRIGHT_W duty, max = full duty
// o_seg      out  7            segments, bit0=a(top),1=b,2=c,3=d,4=e,5=f,6=g(middle)
// o_dp       out  1            decimal point of active digit
// o_an       out  DIGITS       one-hot anode select
// o_frame    out  1            1-cycle pulse when scan wraps digit DIGITS-1 -> 0
// BEHAVIOUR
// - Reset (async, any time incl. mid-scan): prescaler=0, idx=0, display reg=0, dp reg=0,
//   pending valid=0; o_an all inactive, o_seg all inactive, o_dp inactive, o_frame=0.
// - Prescaler counts 0..SCAN_DIV-1; at SCAN_DIV-1 wraps to 0 and idx increments,
//   idx DIGITS-1 -> 0 (DIGITS=1: idx stays 0, wrap every slot). Wrap cycle = frame boundary.
// - o_frame=1 exactly on the cycle after the frame-boundary cycle (registered).
// - i_load: i_val/i_dp -> pending, pending valid=1; repeated loads before commit: last wins.
// - Commit at frame boundary: if pending valid, pending -> display reg, valid=0. i_load on
//   boundary cycle bypasses: i_val/i_dp go straight to display reg, valid=0. Never mid-frame.
// - Sub-slot s = prescaler / (SCAN_DIV>>BRIGHT_W). Digit lit iff s <= i_bright (sampled live).
// - Leading-zero blanking (i_blank_lz=1): from digit DIGITS-1 downward, digits with nibble 0
//   and dp 0 are blank until first nonzero nibble or set dp; digit 0 never blanked.
// - Blank digit: anode still driven per PWM, all segments and dp off.
// - Glyphs (active-high a..g): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//   A=77 b=7C C=39 d=5E E=79 F=71; inverted when SEG_ACT_LOW=1.
// - All outputs registered: pins reflect prescaler/idx state with 1-cycle latency.
// - Unlit cycles: o_an all inactive, o_seg/o_dp inactive (no ghosting).
// STRUCTURE
// - Package segment_pkg: typedef logic [6:0] seg_t; localparam seg_t glyph constants 0..F,
//   SEG_BLANK; function seg_polarity(seg_t, bit act_low).
// - Sub-module segment_glyph_lut (comb): nibble + blank -> seg_t, active-high.
// - Top: prescaler, idx counter, pending/display regs, LZ-blank mask, PWM compare, out regs.
// TESTING (sim params DIGITS=4, SCAN_DIV=16, BRIGHT_W=2, both ACT_LOW=1)
// 1 reset, i_load val=16'h12AF, bright=3 -> o_an cycles 1110,1101,1011,0111 every 16 clk;
//   o_seg 0001110(F),0001000(A),0100100(2),1111001(1); o_frame pulse every 64 clk.
// 2 load 16'h0000 then 16'h0042 within one frame -> only 0042 shown after boundary;
//   display unchanged before boundary; load on boundary cycle shows new value next frame.
// 3 i_blank_lz=1, val=16'h0042, dp=0 -> digits 3,2 seg 1111111/dp off, digits 1,0 "4","2";
//   val=0000 -> digit 0 shows "0"; dp=4'b0100 -> digit 2 shows "0" with dp.
// 4 bright=0 -> each anode active 4 of 16 cycles; bright=2 -> 12 of 16; bright=3 -> 16.
// 5 assert i_rst mid-slot (digit 2, prescaler 7) -> same cycle o_an=1111, o_seg=1111111;
//   after release scan restarts at digit 0 with display reg 0.
// 6 DIGITS=1 build -> o_an=0 (active) per PWM, o_frame every SCAN_DIV cycles.

Source files
------------

// File: rtl/segment_pkg.sv
// Shared types, glyph constants and polarity helper for the hex scan driver.
package segment_pkg;

  // Segment vector, bit0 = a (top) .. bit6 = g (middle), active-high.
  typedef logic [6:0] seg_t;

  localparam seg_t GLYPH_0   = 7'h3F;
  localparam seg_t GLYPH_1   = 7'h06;
  localparam seg_t GLYPH_2   = 7'h5B;
  localparam seg_t GLYPH_3   = 7'h4F;
  localparam seg_t GLYPH_4   = 7'h66;
  localparam seg_t GLYPH_5   = 7'h6D;
  localparam seg_t GLYPH_6   = 7'h7D;
  localparam seg_t GLYPH_7   = 7'h07;
  localparam seg_t GLYPH_8   = 7'h7F;
  localparam seg_t GLYPH_9   = 7'h6F;
  localparam seg_t GLYPH_A   = 7'h77;
  localparam seg_t GLYPH_B   = 7'h7C;
  localparam seg_t GLYPH_C   = 7'h39;
  localparam seg_t GLYPH_D   = 7'h5E;
  localparam seg_t GLYPH_E   = 7'h79;
  localparam seg_t GLYPH_F   = 7'h71;
  localparam seg_t SEG_BLANK = 7'h00;

  // Convert an active-high segment vector to the pin polarity of the board.
  function automatic seg_t seg_polarity(input seg_t seg, input bit act_low);
    return act_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/segment_glyph_lut.sv
// Hex nibble to 7-segment glyph decode (active-high), with forced blank.
module segment_glyph_lut
  import segment_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  output seg_t       o_seg
);

  // Pure lookup; blank overrides the nibble so unlit/blanked slots drive nothing.
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      case (i_nib)
        4'h0:    o_seg = GLYPH_0;
        4'h1:    o_seg = GLYPH_1;
        4'h2:    o_seg = GLYPH_2;
        4'h3:    o_seg = GLYPH_3;
        4'h4:    o_seg = GLYPH_4;
        4'h5:    o_seg = GLYPH_5;
        4'h6:    o_seg = GLYPH_6;
        4'h7:    o_seg = GLYPH_7;
        4'h8:    o_seg = GLYPH_8;
        4'h9:    o_seg = GLYPH_9;
        4'hA:    o_seg = GLYPH_A;
        4'hB:    o_seg = GLYPH_B;
        4'hC:    o_seg = GLYPH_C;
        4'hD:    o_seg = GLYPH_D;
        4'hE:    o_seg = GLYPH_E;
        4'hF:    o_seg = GLYPH_F;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/segment_scan_hex.sv
// Multi-digit time-multiplexed hex display driver: frame-synchronous value
// update, leading-zero blanking, per-digit decimal point and PWM brightness.
module segment_scan_hex
  import segment_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BRIGHT_W    = 4,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*DIGITS-1:0]   i_val,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_load,
  input  logic                  i_blank_lz,
  input  logic [BRIGHT_W-1:0]   i_bright,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_frame
);

  // Sub-slot length; the slot is cut into 2**BRIGHT_W equal sub-slots.
  localparam int SUB_DIV = SCAN_DIV >> BRIGHT_W;
  localparam int PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW      = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(SUB_DIV - 1);
  localparam bit SEG_LOW = (SEG_ACT_LOW != 0);
  localparam bit AN_LOW  = (AN_ACT_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF = AN_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  if (DIGITS < 1 || SUB_DIV < 1 || (SCAN_DIV % (1 << BRIGHT_W)) != 0) begin : g_bad_cfg
    $error("segment_scan_hex: SCAN_DIV must be a nonzero multiple of 2**BRIGHT_W and DIGITS >= 1");
  end

  logic [PW-1:0]         r_presc;
  logic [SW-1:0]         r_sub_cnt;
  logic [BRIGHT_W-1:0]   r_sub;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_disp_val;
  logic [DIGITS-1:0]     r_disp_dp;
  logic [4*DIGITS-1:0]   r_pend_val;
  logic [DIGITS-1:0]     r_pend_dp;
  logic                  r_pend_vld;

  logic                  w_presc_wrap;
  logic                  w_boundary;
  logic                  w_lit;
  logic                  w_lead;
  logic [DIGITS-1:0]     w_blank;
  logic [DIGITS-1:0]     w_an_onehot;
  logic [3:0]            w_nib;
  logic                  w_dig_dp;
  logic                  w_dig_blank;
  logic                  w_dp_on;
  logic [DIGITS-1:0]     w_an_pin;
  seg_t                  w_glyph;

  assign w_presc_wrap = (r_presc == PRESC_LAST);
  assign w_boundary   = w_presc_wrap && (r_idx == IDX_LAST);
  assign w_lit        = (r_sub <= i_bright);

  // Slot timing: prescaler, PWM sub-slot tracker and digit index.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc   <= '0;
      r_sub_cnt <= '0;
      r_sub     <= '0;
      r_idx     <= '0;
    end else if (w_presc_wrap) begin
      r_presc   <= '0;
      r_sub_cnt <= '0;
      r_sub     <= '0;
      r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
      if (r_sub_cnt == SUB_LAST) begin
        r_sub_cnt <= '0;
        r_sub     <= r_sub + BRIGHT_W'(1);
      end else begin
        r_sub_cnt <= r_sub_cnt + SW'(1);
      end
    end
  end

  // Tear-free update: loads park in pending and only reach the display at a frame boundary.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_disp_val <= '0;
      r_disp_dp  <= '0;
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_vld <= 1'b0;
    end else if (w_boundary) begin
      if (i_load) begin
        r_disp_val <= i_val;
        r_disp_dp  <= i_dp;
      end else if (r_pend_vld) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
      end
      r_pend_vld <= 1'b0;
    end else if (i_load) begin
      r_pend_val <= i_val;
      r_pend_dp  <= i_dp;
      r_pend_vld <= 1'b1;
    end
  end

  // Leading-zero mask: walk down from the top digit until a nonzero nibble or set dp.
  always_comb begin
    w_blank = '0;
    w_lead  = i_blank_lz;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (w_lead && (r_disp_val[4*k +: 4] == 4'h0) && !r_disp_dp[k]) begin
        w_blank[k] = 1'b1;
      end else begin
        w_lead = 1'b0;
      end
    end
  end

  // Select the active digit's nibble, dp and blank flag via one-hot AND-OR.
  always_comb begin
    w_an_onehot = '0;
    w_nib       = 4'h0;
    w_dig_dp    = 1'b0;
    w_dig_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      w_an_onehot[k] = (r_idx == IW'(k));
      w_nib          = w_nib | (r_disp_val[4*k +: 4] & {4{w_an_onehot[k]}});
      w_dig_dp       = w_dig_dp | (r_disp_dp[k] & w_an_onehot[k]);
      w_dig_blank    = w_dig_blank | (w_blank[k] & w_an_onehot[k]);
    end
  end

  segment_glyph_lut u_lut (
    .i_nib   (w_nib),
    .i_blank (w_dig_blank | ~w_lit),
    .o_seg   (w_glyph)
  );

  // Anode and dp pin values; unlit sub-slots drive everything inactive.
  always_comb begin
    w_dp_on = w_lit & ~w_dig_blank & w_dig_dp;
    if (!w_lit) begin
      w_an_pin = AN_OFF;
    end else if (AN_LOW) begin
      w_an_pin = ~w_an_onehot;
    end else begin
      w_an_pin = w_an_onehot;
    end
  end

  // Output registers so the pins never glitch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_an    <= AN_OFF;
      o_seg   <= seg_polarity(SEG_BLANK, SEG_LOW);
      o_dp    <= SEG_LOW;
      o_frame <= 1'b0;
    end else begin
      o_an    <= w_an_pin;
      o_seg   <= seg_polarity(w_glyph, SEG_LOW);
      o_dp    <= w_dp_on ^ SEG_LOW;
      o_frame <= w_boundary;
    end
  end

endmodule
